mux_nto1_stream: RTL and testbench
==================================

// Module: mux_nto1_stream
// PURPOSE
//  Parametrised N:1 stream multiplexer; successor to the combinational 4:1 mux.
//  Selects one of N W-bit channels and holds it in a registered output stage with a valid/ready handshake.
//  Two select modes: manual (external sel) or round-robin arbitration.
//  Sits between multiple producers and a single downstream consumer.
// PARAMETERS
//  N   4  number of input channels (>=2; need not be a power of 2)
//  W   8  data width per channel
//  SW  $clog2(N)  localparam, select/channel-index width
// PORTS
//  clk        in   1    clock, all logic on rising edge
//  rst        in   1    synchronous reset, active-high
//  mode       in   1    0 = manual select, 1 = round-robin
//  sel        in   SW   channel index in manual mode; ignored in round-robin
//  in_data    in   N*W  channel k at in_data[k*W +: W]
//  in_valid   in   N    per-channel valid
//  in_ready   out  N    per-channel ready; at most one bit high per cycle
//  out_data   out  W    registered selected data
//  out_valid  out  1    out_data/out_chan hold a word
//  out_ready  in   1    consumer accepts the word
//  out_chan   out  SW   index of the channel out_data came from
//  out_parity out  1    present only with MUX_PARITY_EN
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge):
//    - out_valid=0, out_data=0, out_chan=0.
//    - rr pointer last=N-1, so channel 0 has first priority.
//    - A word held at reset is discarded.
//  - load = !out_valid || out_ready.
//    - Output stage is one entry; draining and reloading in the same cycle is allowed (1 word/cycle).
//  - Grant, combinational:
//    - Manual: g=sel. If sel>=N there is no grant and in_ready=0.
//    - Round-robin: g = first k with in_valid[k]=1, scanning last+1, last+2, ... mod N.
//      No valid channel -> no grant.
//  - in_ready[k] = load && (grant exists) && (g==k).
//    - in_ready may depend combinationally on out_ready.
//    - in_ready never depends on in_valid[k] of the same channel in manual mode.
//  - Transfer on channel k: in_valid[k] && in_ready[k] at a clk edge.
//    - Next cycle: out_data=in_data[k], out_chan=k, out_valid=1. Latency 1 clk.
//  - If load=1 and there is no transfer: out_valid<=0.
//  - If load=0: out_data, out_chan, out_valid hold their values (stable under backpressure).
//  - rr pointer: last<=k only on a transfer made while mode=1.
//    - Manual-mode transfers leave last unchanged.
//  - Wrap-around: after last=N-1 the scan restarts at channel 0.
//  - A mode or sel change takes effect on the next grant; an already held word is unaffected.
//  - Fairness: with all N valid continuously and out_ready=1, grants run 0,1,..,N-1,0,... with no repeats.
// CONFIGURATION
//  MUX_PARITY_EN
//  - Defined: out_parity port exists. It is registered with out_data as ^in_data[k] (even parity).
//    It follows the same reset (0) and hold rules as out_data.
//  - Undefined: no out_parity port and no parity logic; all other behaviour is identical.
// TESTING
//  1. Reset with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0 while rst=1.
//     First RR grant after reset is ch0.
//  2. Manual, sel=2, in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1
//     -> next cycle out_data=A5, out_chan=2, out_valid=1.
//  3. RR, N=4, all valid, out_ready=1 for 6 cycles -> out_chan sequence 0,1,2,3,0,1.
//  4. out_ready=0 with a word held -> in_ready=0 and out_data stable.
//     Raising out_ready with ch1 valid -> drain and reload in the same cycle; out_valid stays 1.
//  5. N=3, manual, sel=3 -> in_ready=3'b000 and out_valid drops after the held word drains.
//  6. rst asserted while out_valid=1 and out_ready=0 -> word dropped, out_valid=0 the next cycle.
//     With MUX_PARITY_EN, data 8'h07 -> out_parity=1.

Source files
------------

// File: rtl/mux_nto1_stream.sv
// N:1 stream multiplexer with a one-entry registered output stage, selected manually or by round-robin.
// Optional even-parity output enabled by defining MUX_PARITY_EN.
module mux_nto1_stream #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8,
  localparam int unsigned SW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [SW-1:0]     sel,
  input  logic [N*W-1:0]    in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SW-1:0]     out_chan
`ifdef MUX_PARITY_EN
  ,
  output logic              out_parity
`endif
);

  logic [SW-1:0] last;
  logic [SW-1:0] rr_idx;
  logic          rr_found;
  logic [SW-1:0] cidx;
  int unsigned   cand;
  logic          man_ok;
  logic [SW-1:0] grant;
  logic          grant_ok;
  logic          load;
  logic          xfer;
  logic [W-1:0]  sel_data;

  assign load = !out_valid || out_ready;

  // Manual select is always in range when N is a power of two.
  if ((1 << SW) == N) begin : g_pow2
    assign man_ok = 1'b1;
  end else begin : g_npow2
    assign man_ok = (sel < SW'(N));
  end

  // Scan last+1 .. last+N (mod N); the first valid channel wins.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = 0;
    cidx     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = (32'(last) + i + 1) % N;
      cidx = SW'(cand);
      if (!rr_found && in_valid[cidx]) begin
        rr_found = 1'b1;
        rr_idx   = cidx;
      end
    end
  end

  assign grant    = mode ? rr_idx : sel;
  assign grant_ok = mode ? rr_found : man_ok;

  always_comb begin
    in_ready = '0;
    for (int unsigned k = 0; k < N; k++) begin
      in_ready[k] = !rst && load && grant_ok && (grant == SW'(k));
    end
  end

  assign xfer = |(in_valid & in_ready);

  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (grant == SW'(k)) sel_data = in_data[k*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      last      <= SW'(N - 1);
    end else if (load) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_chan  <= grant;
        if (mode) last <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_parity <= 1'b0;
    end else if (load && xfer) begin
      out_parity <= ^sel_data;
    end
  end
`endif

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Self-checking bench for mux_nto1_stream: directed scenarios on N=4 and N=3 instances plus a randomized run.
module tb_mux_nto1_stream;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_chan;

  logic        mode3;
  logic [1:0]  sel3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic        out_valid3;
  logic        out_ready3;
  logic [1:0]  out_chan3;
`ifdef MUX_PARITY_EN
  logic        out_parity;
  logic        out_parity3;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mux_nto1_stream #(.N(4), .W(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_chan(out_chan)
`ifdef MUX_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  mux_nto1_stream #(.N(3), .W(8)) dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_chan(out_chan3)
`ifdef MUX_PARITY_EN
    , .out_parity(out_parity3)
`endif
  );

  task automatic do_reset();
    rst = 1'b1;
    mode = 1'b0; sel = '0; in_data = '0; in_valid = '0; out_ready = 1'b1;
    mode3 = 1'b0; sel3 = '0; in_data3 = '0; in_valid3 = '0; out_ready3 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b1; in_valid = 4'hF; in_data = 32'h44332211; out_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", out_valid); end
    tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL reset_data got %h want 00", out_data); end
    tests++; if (out_chan !== 2'd0) begin fails++; $display("FAIL reset_chan got %0d want 0", out_chan); end
    tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready got %b want 0000", in_ready); end
    rst = 1'b0; #1;
    tests++; if (in_ready !== 4'b0001) begin fails++; $display("FAIL first_rr_ready got %b want 0001", in_ready); end
    @(posedge clk); #1;
    tests++; if (out_chan !== 2'd0 || out_valid !== 1'b1 || out_data !== 8'h11) begin
      fails++; $display("FAIL first_rr_out got chan=%0d v=%b d=%h want chan=0 v=1 d=11", out_chan, out_valid, out_data);
    end
  endtask

  task automatic test_manual();
    do_reset();
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
    in_data = {8'($urandom), 8'hA5, 8'($urandom), 8'($urandom)};
    #1;
    tests++; if (in_ready !== 4'b0100) begin fails++; $display("FAIL manual_ready got %b want 0100", in_ready); end
    @(posedge clk); #1;
    tests++; if (out_data !== 8'hA5 || out_chan !== 2'd2 || out_valid !== 1'b1) begin
      fails++; $display("FAIL manual_out got d=%h chan=%0d v=%b want d=a5 chan=2 v=1", out_data, out_chan, out_valid);
    end
  endtask

  task automatic test_rr_fair();
    int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1; in_data = 32'h13121110;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      tests++; if (out_chan !== 2'(exp_seq[i]) || out_data !== 8'(8'h10 + exp_seq[i]) || out_valid !== 1'b1) begin
        fails++; $display("FAIL rr_seq[%0d] got chan=%0d d=%h want chan=%0d", i, out_chan, out_data, exp_seq[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_data = 32'h0000003C; out_ready = 1'b0;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b1 || out_data !== 8'h3C) begin fails++; $display("FAIL bp_load got v=%b d=%h want v=1 d=3c", out_valid, out_data); end
    sel = 2'd1; in_valid = 4'b0011; in_data = 32'h00009A55; #1;
    tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL bp_ready got %b want 0000", in_ready); end
    @(posedge clk); #1;
    tests++; if (out_data !== 8'h3C || out_chan !== 2'd0 || out_valid !== 1'b1) begin
      fails++; $display("FAIL bp_hold got d=%h chan=%0d v=%b want d=3c chan=0 v=1", out_data, out_chan, out_valid);
    end
    out_ready = 1'b1; #1;
    tests++; if (in_ready !== 4'b0010) begin fails++; $display("FAIL b2b_ready got %b want 0010", in_ready); end
    @(posedge clk); #1;
    tests++; if (out_data !== 8'h9A || out_chan !== 2'd1 || out_valid !== 1'b1) begin
      fails++; $display("FAIL b2b_out got d=%h chan=%0d v=%b want d=9a chan=1 v=1", out_data, out_chan, out_valid);
    end
  endtask

  task automatic test_n3();
    int exp_seq[4] = '{0, 1, 2, 0};
    do_reset();
    mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b001; in_data3 = 24'h00005A; out_ready3 = 1'b0;
    @(posedge clk); #1;
    tests++; if (out_valid3 !== 1'b1 || out_data3 !== 8'h5A) begin fails++; $display("FAIL n3_load got v=%b d=%h want v=1 d=5a", out_valid3, out_data3); end
    sel3 = 2'd3; in_valid3 = 3'b111; #1;
    tests++; if (in_ready3 !== 3'b000) begin fails++; $display("FAIL n3_sel3_ready_held got %b want 000", in_ready3); end
    @(posedge clk); #1;
    tests++; if (out_valid3 !== 1'b1) begin fails++; $display("FAIL n3_held got v=%b want 1", out_valid3); end
    out_ready3 = 1'b1; #1;
    tests++; if (in_ready3 !== 3'b000) begin fails++; $display("FAIL n3_sel3_ready got %b want 000", in_ready3); end
    @(posedge clk); #1;
    tests++; if (out_valid3 !== 1'b0) begin fails++; $display("FAIL n3_drain got v=%b want 0", out_valid3); end
    mode3 = 1'b1; in_data3 = 24'h2B1A0F;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      tests++; if (out_chan3 !== 2'(exp_seq[i]) || out_valid3 !== 1'b1) begin
        fails++; $display("FAIL n3_rr_wrap[%0d] got chan=%0d v=%b want chan=%0d", i, out_chan3, out_valid3, exp_seq[i]);
      end
    end
  endtask

  task automatic test_reset_drop();
    do_reset();
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; in_data = 32'h00000700; out_ready = 1'b0;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b1 || out_data !== 8'h07) begin fails++; $display("FAIL drop_load got v=%b d=%h want v=1 d=07", out_valid, out_data); end
`ifdef MUX_PARITY_EN
    tests++; if (out_parity !== 1'b1) begin fails++; $display("FAIL parity_07 got %b want 1", out_parity); end
`endif
    rst = 1'b1; in_valid = '0;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin fails++; $display("FAIL drop_reset got v=%b d=%h want v=0 d=00", out_valid, out_data); end
`ifdef MUX_PARITY_EN
    tests++; if (out_parity !== 1'b0) begin fails++; $display("FAIL parity_reset got %b want 0", out_parity); end
`endif
    rst = 1'b0;
  endtask

  // Reference: single held word, rr pointer as an integer, grant found by modular scan.
  task automatic test_random();
    int m_valid, m_data, m_chan, m_last, g;
    bit has, load;
    logic [3:0] exp_ready;
    do_reset();
    m_valid = 0; m_data = 0; m_chan = 0; m_last = N - 1;
    for (int t = 0; t < 400; t++) begin
      rst = ($urandom_range(0, 49) == 0);
      mode = 1'($urandom_range(0, 1));
      sel = 2'($urandom);
      in_valid = 4'($urandom);
      in_data = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      has = 0; g = 0;
      if (mode) begin
        for (int j = 1; j <= N; j++) begin
          if (!has && in_valid[(m_last + j) % N]) begin has = 1; g = (m_last + j) % N; end
        end
      end else begin
        has = (int'(sel) < N); g = int'(sel);
      end
      load = (m_valid == 0) || out_ready;
      exp_ready = (!rst && load && has) ? 4'(1 << g) : 4'b0000;
      #1;
      tests++; if (in_ready !== exp_ready) begin fails++; $display("FAIL rand_ready[%0d] got %b want %b", t, in_ready, exp_ready); end
      @(posedge clk);
      if (rst) begin
        m_valid = 0; m_data = 0; m_chan = 0; m_last = N - 1;
      end else if (load) begin
        if (has && in_valid[g]) begin
          m_valid = 1; m_data = int'(in_data[g*8 +: 8]); m_chan = g;
          if (mode) m_last = g;
        end else begin
          m_valid = 0;
        end
      end
      #1;
      tests++; if (out_valid !== 1'(m_valid)) begin fails++; $display("FAIL rand_valid[%0d] got %b want %0d", t, out_valid, m_valid); end
      if (m_valid != 0) begin
        tests++; if (out_data !== 8'(m_data) || out_chan !== 2'(m_chan)) begin
          fails++; $display("FAIL rand_out[%0d] got d=%h chan=%0d want d=%h chan=%0d", t, out_data, out_chan, m_data, m_chan);
        end
`ifdef MUX_PARITY_EN
        tests++; if (out_parity !== ^(8'(m_data))) begin fails++; $display("FAIL rand_parity[%0d] got %b", t, out_parity); end
`endif
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_manual();
    test_rr_fair();
    test_back_to_back();
    test_n3();
    test_reset_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
